// File: rtl/pcs_pattern_pkg.sv
// Shared constants and types for the PCS lane-FIFO pattern generator and checker.
package pcs_pattern_pkg;
  localparam int WORD_W    = 12;
  localparam int NUM_WORDS = 4;
  localparam int BEAT_W    = WORD_W * NUM_WORDS;

  localparam logic [WORD_W-1:0] IDLE        = 12'h555;
  localparam logic [WORD_W-1:0] SYNC        = 12'hAAA;
  localparam logic [3:0]        LANEOK_HEAD = 4'hB;

  typedef enum logic [1:0] {S_OFF, S_SYNC, S_DATA, S_GAP} gen_state_e;
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] beat_t;
endpackage

// File: rtl/gen_pattern_beat.sv
// Combinational beat builder: idle/sync fill or counter words base+k, with word1 flipped on inject.
module gen_pattern_beat
  import pcs_pattern_pkg::*;
(
  input  logic [WORD_W-1:0] base,
  input  logic              sync,
  input  logic              idle,
  input  logic              inject,
  output logic [BEAT_W-1:0] beat
);
  beat_t words;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    logic [WORD_W-1:0] flip;
    assign flip     = (k == 1 && inject) ? 12'h001 : 12'h000;
    assign words[k] = idle ? IDLE :
                      sync ? SYNC :
                      (base + WORD_W'(k)) ^ flip;
  end

  assign beat = words;
endmodule

// File: rtl/gen_tx_fifo.sv
// TX-side pattern source: SYNC preamble, then incrementing counter beats with optional gaps,
// resync and single-beat error injection over a valid/ready handshake.
module gen_tx_fifo
  import pcs_pattern_pkg::*;
#(
  parameter int SYNC_BEATS = 4,
  parameter int STEP       = 16,
  parameter int BURST_LEN  = 0,
  parameter int GAP_LEN    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              resync_req,
  input  logic              err_inject,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sync,
  output logic [15:0]       beat_cnt
);
  gen_state_e        state, state_n;
  logic [WORD_W-1:0] base, base_n;
  logic [15:0]       sync_cnt, sync_cnt_n, burst_cnt, burst_cnt_n, gap_cnt, gap_cnt_n;
  logic [15:0]       beat_cnt_n;
  logic              inj_pend, inj_pend_n, resync_pend, resync_pend_n;
  logic              beat_inj;
  logic              accept, hold;
  logic              gen_idle, gen_sync, gen_inj;
  logic [BEAT_W-1:0] beat_n;

  assign accept = out_valid && out_ready;
  assign hold   = out_valid && !out_ready;

  always_comb begin
    state_n       = state;
    base_n        = base;
    sync_cnt_n    = sync_cnt;
    burst_cnt_n   = burst_cnt;
    gap_cnt_n     = gap_cnt;
    beat_cnt_n    = beat_cnt;
    // Only the beat actually carrying the flip retires the pending injection.
    inj_pend_n    = (inj_pend && !(accept && beat_inj)) || err_inject;
    resync_pend_n = resync_pend || resync_req;
    case (state)
      S_OFF: begin
        resync_pend_n = 1'b0;
        if (enable) begin
          state_n    = S_SYNC;
          sync_cnt_n = '0;
        end
      end
      S_SYNC: if (accept) begin
        if (!enable) begin
          state_n       = S_OFF;
          resync_pend_n = 1'b0;
        end else if (resync_pend) begin
          sync_cnt_n    = '0;
          resync_pend_n = 1'b0;
        end else if (sync_cnt == 16'(SYNC_BEATS - 1)) begin
          state_n     = S_DATA;
          base_n      = SYNC + WORD_W'(STEP);
          burst_cnt_n = '0;
        end else begin
          sync_cnt_n = sync_cnt + 16'd1;
        end
      end
      S_DATA: if (accept) begin
        base_n     = base + WORD_W'(STEP);
        beat_cnt_n = beat_cnt + 16'd1;
        if (!enable) begin
          state_n       = S_OFF;
          resync_pend_n = 1'b0;
          burst_cnt_n   = '0;
        end else if (resync_pend) begin
          state_n       = S_SYNC;
          sync_cnt_n    = '0;
          resync_pend_n = 1'b0;
          burst_cnt_n   = '0;
        end else if (BURST_LEN != 0 && burst_cnt == 16'(BURST_LEN - 1)) begin
          state_n     = S_GAP;
          burst_cnt_n = '0;
          gap_cnt_n   = '0;
        end else begin
          burst_cnt_n = burst_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_n       = S_OFF;
          resync_pend_n = 1'b0;
        end else if (resync_pend) begin
          state_n       = S_SYNC;
          sync_cnt_n    = '0;
          resync_pend_n = 1'b0;
        end else if (gap_cnt == 16'(GAP_LEN - 1)) begin
          state_n = S_DATA;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end
      default: state_n = S_OFF;
    endcase
  end

  assign gen_idle = (state_n == S_OFF) || (state_n == S_GAP);
  assign gen_sync = (state_n == S_SYNC);
  assign gen_inj  = (state_n == S_DATA) && inj_pend_n;

  gen_pattern_beat u_beat (
    .base   (base_n),
    .sync   (gen_sync),
    .idle   (gen_idle),
    .inject (gen_inj),
    .beat   (beat_n)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_OFF;
      base        <= '0;
      sync_cnt    <= '0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      inj_pend    <= 1'b0;
      resync_pend <= 1'b0;
      beat_inj    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sync    <= 1'b0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      sync_cnt    <= sync_cnt_n;
      burst_cnt   <= burst_cnt_n;
      gap_cnt     <= gap_cnt_n;
      beat_cnt    <= beat_cnt_n;
      inj_pend    <= inj_pend_n;
      resync_pend <= resync_pend_n;
      // A presented-but-unaccepted beat is frozen; state cannot advance either.
      if (!hold) begin
        out_data  <= beat_n;
        out_valid <= (state_n == S_SYNC) || (state_n == S_DATA);
        out_sync  <= gen_sync;
        beat_inj  <= gen_inj;
      end
    end
  end
endmodule

// File: tb/tb_gen_tx_fifo.sv
// Directed bench for gen_tx_fifo: default instance for startup/backpressure/wrap/inject/reset,
// burst instance (BURST_LEN=3, GAP_LEN=2) for gaps and resync.
module tb_gen_tx_fifo;
  logic        clk = 1'b0;
  logic        reset_n, en_a, en_b, resync_req, err_inject, out_ready;
  logic [47:0] data_a, data_b;
  logic        valid_a, valid_b, sync_a, sync_b;
  logic [15:0] cnt_a, cnt_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  gen_tx_fifo u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .resync_req(resync_req),
    .err_inject(err_inject), .out_ready(out_ready), .out_data(data_a),
    .out_valid(valid_a), .out_sync(sync_a), .beat_cnt(cnt_a)
  );

  gen_tx_fifo #(.BURST_LEN(3), .GAP_LEN(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .resync_req(resync_req),
    .err_inject(err_inject), .out_ready(out_ready), .out_data(data_b),
    .out_valid(valid_b), .out_sync(sync_b), .beat_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] dbeat(input logic [11:0] b);
    return {b + 12'd3, b + 12'd2, b + 12'd1, b};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0]  vpat;
    logic [11:0] exp_b;
    int          guard;

    reset_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    resync_req = 1'b0; err_inject = 1'b0; out_ready = 1'b1;
    tick; tick;
    check("rst_valid", valid_a, 1'b0);
    check("rst_data",  data_a, 48'h0);
    check("rst_sync",  sync_a, 1'b0);
    check("rst_cnt",   cnt_a, 16'd0);

    // startup preamble and first data beats
    reset_n = 1'b1; en_a = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("sync_data", data_a, 48'hAAAAAAAAAAAA);
      check("sync_flag", {valid_a, sync_a}, 2'b11);
      tick;
    end
    check("d0", data_a, 48'hABDABCABBABA);
    check("d0_sync", {valid_a, sync_a}, 2'b10);
    tick;
    check("d1", data_a, 48'hACDACCACBACA);
    tick;
    check("cnt2", cnt_a, 16'd2);
    check("bp_pre", data_a, 48'hADDADCADBADA);

    // backpressure hold
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("bp_hold", data_a, 48'hADDADCADBADA);
      check("bp_valid", {valid_a, sync_a}, 2'b10);
    end
    check("bp_cnt_hold", cnt_a, 16'd2);
    out_ready = 1'b1;
    tick;
    check("bp_next", data_a, 48'hAEDAECAEBAEA);
    check("bp_cnt", cnt_a, 16'd3);

    // counter wrap
    guard = 0;
    while (data_a[11:0] != 12'hFFA && guard < 200) begin tick; guard++; end
    check("wrap_reach", data_a, 48'hFFDFFCFFBFFA);
    check("wrap_cnt", cnt_a, 16'd84);
    tick;
    check("wrap_next", data_a, 48'h00D00C00B00A);

    // single-beat injection
    guard = 0;
    while (data_a[11:0] != 12'hAFA && guard < 300) begin tick; guard++; end
    check("inj_pre", data_a, 48'hAFDAFCAFBAFA);
    err_inject = 1'b1;
    tick;
    err_inject = 1'b0;
    check("inj_beat", data_a, 48'hB0DB0CB0AB0A);
    tick;
    check("inj_clear", data_a, 48'hB1DB1CB1BB1A);

    // enable drop
    en_a = 1'b0;
    tick;
    check("off_valid", valid_a, 1'b0);
    check("off_data", data_a, 48'h555555555555);
    check("off_cnt", cnt_a, 16'd263);

    // restart, then reset mid-operation
    en_a = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) tick;
    check("re_data", data_a, 48'hABDABCABBABA);
    check("re_cnt", cnt_a, 16'd263);
    reset_n = 1'b0;
    tick;
    check("mid_rst", {valid_a, sync_a, cnt_a, data_a}, 66'h0);
    reset_n = 1'b1;
    tick;
    check("rst_restart", {valid_a, sync_a, data_a}, {2'b11, 48'hAAAAAAAAAAAA});
    en_a = 1'b0;

    // burst/gap instance
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1; en_b = 1'b1;
    tick;
    check("b_sync", {valid_b, sync_b, data_b}, {2'b11, 48'hAAAAAAAAAAAA});
    for (int i = 0; i < 4; i++) tick;
    vpat  = 10'b0011100111;
    exp_b = 12'hABA;
    for (int i = 0; i < 10; i++) begin
      check("burst_valid", valid_b, vpat[i]);
      if (vpat[i]) begin
        check("burst_data", data_b, dbeat(exp_b));
        exp_b = exp_b + 12'h010;
      end
      tick;
    end
    check("b_cnt", cnt_b, 16'd6);
    check("b_data", data_b, 48'hB1DB1CB1BB1A);

    // resync + inject together mid-burst, with the beat held
    out_ready = 1'b0; resync_req = 1'b1; err_inject = 1'b1;
    tick;
    resync_req = 1'b0; err_inject = 1'b0;
    check("rs_hold", {valid_b, data_b}, {1'b1, 48'hB1DB1CB1BB1A});
    out_ready = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("rs_sync", {valid_b, sync_b, data_b}, {2'b11, 48'hAAAAAAAAAAAA});
      tick;
    end
    check("rs_inj", data_b, 48'hABDABCABAABA);
    check("rs_cnt", cnt_b, 16'd7);
    tick;
    check("rs_d1", data_b, 48'hACDACCACBACA);
    tick;
    check("rs_d2", data_b, 48'hADDADCADBADA);
    tick;
    check("rs_gap", valid_b, 1'b0);
    en_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
